// File: rtl/cmd_loader.sv
// cmd_loader: parses a TRS-80 /CMD file arriving as a byte-write stream
// from the SPI download stage. Data records become RAM writes at their
// load addresses, and the transfer record's entry point is captured.
// Optional raw mode (macro CMD_LOADER_RAW_EN) bypasses the parser and
// writes every byte linearly from RAW_BASE.
module cmd_loader #(
    parameter int          MAX_SKIP = 9,
    parameter logic [15:0] RAW_BASE = 16'h4200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        downloading,
    input  logic        in_wr,
    input  logic [7:0]  in_data,
`ifdef CMD_LOADER_RAW_EN
    input  logic        raw_mode,
`endif
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [15:0] exec_addr,
    output logic        exec_valid,
    output logic        load_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_TYPE, S_LEN01, S_ADLO, S_ADHI, S_DATA,
        S_LEN02, S_XLO, S_XHI, S_LENSKIP, S_SKIP, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 dl_q;
    logic [MAX_SKIP-1:0]  cnt_q, cnt_d;
    logic [15:0]          ptr_q, ptr_d;
    logic [7:0]           xlo_q, xlo_d;
    logic [15:0]          exec_addr_q, exec_addr_d;
    logic                 exec_valid_q, exec_valid_d;
    logic                 load_err_q, load_err_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [15:0]          mem_addr_q, mem_addr_d;
    logic [7:0]           mem_data_q, mem_data_d;
    logic                 dl_rise, dl_fall, end_dirty;
`ifdef CMD_LOADER_RAW_EN
    logic                 raw_q, raw_d;
`endif

    assign dl_rise = downloading & ~dl_q;
    assign dl_fall = ~downloading & dl_q;

    // State and datapath registers; reset clears everything, aborting any record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            xlo_q        <= '0;
            exec_addr_q  <= '0;
            exec_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
`ifdef CMD_LOADER_RAW_EN
            raw_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dl_q         <= downloading;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            xlo_q        <= xlo_d;
            exec_addr_q  <= exec_addr_d;
            exec_valid_q <= exec_valid_d;
            load_err_q   <= load_err_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
`ifdef CMD_LOADER_RAW_EN
            raw_q        <= raw_d;
`endif
        end
    end

    // Record parser: download edges take priority, otherwise advance one byte per in_wr.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        xlo_d        = xlo_q;
        exec_addr_d  = exec_addr_q;
        exec_valid_d = exec_valid_q;
        load_err_d   = load_err_q;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        end_dirty    = (state_q != S_TYPE) && (state_q != S_DONE);
`ifdef CMD_LOADER_RAW_EN
        raw_d        = raw_q;
        if (raw_q) end_dirty = 1'b0;
`endif
        if (dl_rise) begin
            // A byte coinciding with the start edge is dropped.
            state_d      = S_TYPE;
            exec_valid_d = 1'b0;
            load_err_d   = 1'b0;
            ptr_d        = RAW_BASE;
`ifdef CMD_LOADER_RAW_EN
            raw_d        = raw_mode;
            if (raw_mode) state_d = S_IDLE;
`endif
        end else if (dl_fall) begin
            if (end_dirty) load_err_d = 1'b1;
            state_d = S_IDLE;
`ifdef CMD_LOADER_RAW_EN
            raw_d   = 1'b0;
`endif
        end else if (in_wr) begin
`ifdef CMD_LOADER_RAW_EN
            if (raw_q) begin
                mem_wr_d   = 1'b1;
                mem_addr_d = ptr_q;
                mem_data_d = in_data;
                ptr_d      = ptr_q + 16'd1;
            end else
`endif
            case (state_q)
                S_TYPE: begin
                    if (in_data == 8'h01)      state_d = S_LEN01;
                    else if (in_data == 8'h02) state_d = S_LEN02;
                    else                       state_d = S_LENSKIP;
                end
                S_LEN01: begin
                    // Length includes the two address bytes; 0..2 wrap to 254..256.
                    if (in_data < 8'd3) cnt_d = MAX_SKIP'(in_data) + MAX_SKIP'(254);
                    else                cnt_d = MAX_SKIP'(in_data) - MAX_SKIP'(2);
                    state_d = S_ADLO;
                end
                S_ADLO: begin
                    ptr_d   = {ptr_q[15:8], in_data};
                    state_d = S_ADHI;
                end
                S_ADHI: begin
                    ptr_d   = {in_data, ptr_q[7:0]};
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = in_data;
                    ptr_d      = ptr_q + 16'd1;
                    cnt_d      = cnt_q - MAX_SKIP'(1);
                    if (cnt_q == MAX_SKIP'(1)) state_d = S_TYPE;
                end
                S_LEN02:   state_d = S_XLO;
                S_XLO: begin
                    xlo_d   = in_data;
                    state_d = S_XHI;
                end
                S_XHI: begin
                    exec_addr_d  = {in_data, xlo_q};
                    exec_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
                S_LENSKIP: begin
                    cnt_d   = (in_data == 8'h00) ? MAX_SKIP'(256) : MAX_SKIP'(in_data);
                    state_d = S_SKIP;
                end
                S_SKIP: begin
                    cnt_d = cnt_q - MAX_SKIP'(1);
                    if (cnt_q == MAX_SKIP'(1)) state_d = S_TYPE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign exec_addr  = exec_addr_q;
    assign exec_valid = exec_valid_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_cmd_loader.sv
// Bench for cmd_loader: directed /CMD streams plus randomized files,
// compared against a record-level reference parser.
module tb_cmd_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0;
    logic        in_wr = 1'b0;
    logic [7:0]  in_data = 8'h00;
`ifdef CMD_LOADER_RAW_EN
    logic        raw_mode = 1'b0;
`endif
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] exec_addr;
    logic        exec_valid;
    logic        load_err;

    cmd_loader dut (
        .clk        (clk),
        .reset      (reset),
        .downloading(downloading),
        .in_wr      (in_wr),
        .in_data    (in_data),
`ifdef CMD_LOADER_RAW_EN
        .raw_mode   (raw_mode),
`endif
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .exec_addr  (exec_addr),
        .exec_valid (exec_valid),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  stim[$];
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [15:0] exp_xa = 16'h0000;
    logic        exp_xv;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Collect every RAM write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) got_q.push_back({mem_addr, mem_data});
    end

    // Reference parser working record by record over the whole file.
    task automatic model_run(input bit raw);
        int i, n, N;
        logic [7:0]  t, L;
        logic [15:0] a;
        bit stop;
        exp_q.delete();
        exp_err = 1'b0;
        exp_xv  = 1'b0;
        n = stim.size();
        i = 0;
        stop = 1'b0;
        if (raw) begin
            a = 16'h4200;
            foreach (stim[k]) begin
                exp_q.push_back({a, stim[k]});
                a = a + 16'd1;
            end
            return;
        end
        while (!stop && i < n) begin
            t = stim[i]; i++;
            if (i >= n) begin exp_err = 1'b1; break; end
            L = stim[i]; i++;
            if (t == 8'h01) begin
                N = (L < 8'd3) ? int'(L) + 254 : int'(L) - 2;
                if (i + 2 > n) begin exp_err = 1'b1; break; end
                a = {stim[i+1], stim[i]};
                i += 2;
                for (int k = 0; k < N; k++) begin
                    if (i >= n) begin exp_err = 1'b1; stop = 1'b1; break; end
                    exp_q.push_back({a, stim[i]});
                    a = a + 16'd1;
                    i++;
                end
            end else if (t == 8'h02) begin
                if (i + 2 > n) begin exp_err = 1'b1; break; end
                exp_xa = {stim[i+1], stim[i]};
                exp_xv = 1'b1;
                stop = 1'b1;
            end else begin
                N = (L == 8'h00) ? 256 : int'(L);
                if (i + N > n) begin exp_err = 1'b1; break; end
                i += N;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_wr = 1'b1;
        in_data = b;
        @(negedge clk);
        in_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_download(input string name, input bit raw);
        int m;
        got_q.delete();
`ifdef CMD_LOADER_RAW_EN
        raw_mode = raw;
`endif
        @(negedge clk);
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_start_err"}, load_err, 0);
        check({name, "_start_xv"}, exec_valid, 0);
        check({name, "_start_xa"}, exec_addr, exp_xa);
        model_run(raw);
        foreach (stim[k]) send_byte(stim[k]);
        downloading = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_nwr"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) check({name, "_wr"}, got_q[k], exp_q[k]);
        check({name, "_xv"}, exec_valid, exp_xv);
        check({name, "_xa"}, exec_addr, exp_xa);
        check({name, "_err"}, load_err, exp_err);
        check({name, "_wr_idle"}, mem_wr, 0);
    endtask

    task automatic push_list(input logic [7:0] b[]);
        foreach (b[k]) stim.push_back(b[k]);
    endtask

    task automatic gen_random();
        int nrec, kind, L, N;
        stim.delete();
        nrec = $urandom_range(1, 4);
        for (int r = 0; r < nrec; r++) begin
            kind = $urandom % 2;
            if (kind == 0) begin
                L = ($urandom % 16 == 0) ? $urandom_range(0, 2) : $urandom_range(3, 12);
                N = (L < 3) ? L + 254 : L - 2;
                stim.push_back(8'h01);
                stim.push_back(8'(L));
                stim.push_back(8'($urandom));
                stim.push_back(($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
                for (int k = 0; k < N; k++) stim.push_back(8'($urandom));
            end else begin
                L = ($urandom % 12 == 0) ? 0 : $urandom_range(1, 8);
                N = (L == 0) ? 256 : L;
                stim.push_back(($urandom % 2) ? 8'h00 : 8'($urandom_range(3, 255)));
                stim.push_back(8'(L));
                for (int k = 0; k < N; k++) stim.push_back(8'($urandom));
            end
        end
        if ($urandom % 2) begin
            stim.push_back(8'h02);
            stim.push_back(8'h02);
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom));
            for (int k = 0; k < 3; k++) stim.push_back(8'($urandom_range(1, 2)));
        end
        if ($urandom % 3 == 0) begin
            N = $urandom_range(0, stim.size() - 1);
            while (stim.size() > N) void'(stim.pop_back());
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_exec_addr", exec_addr, 0);
        check("rst_exec_valid", exec_valid, 0);
        check("rst_load_err", load_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Bytes outside a download are ignored
        send_byte(8'h01);
        send_byte(8'h05);
        check("idle_nowr", got_q.size(), 0);

        // Basic record plus transfer address
        stim.delete();
        push_list('{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52});
        run_download("basic", 1'b0);
        check("basic_xa_const", exec_addr, 16'h5200);
        check("basic_w2_const", got_q.size() > 2 ? got_q[2] : 24'h0, 24'h5202CC);

        // L=2 gives 256 data bytes
        stim.delete();
        push_list('{8'h01, 8'h02, 8'h00, 8'h70});
        for (int k = 0; k < 256; k++) stim.push_back(8'(k));
        push_list('{8'h02, 8'h02, 8'h34, 8'h12});
        run_download("len256", 1'b0);
        check("len256_xa_const", exec_addr, 16'h1234);
        check("len256_last_const", got_q.size() > 255 ? got_q[255] : 24'h0, 24'h70FFFF);

        // Skip record, write at FFFF, then wrap across the address space
        stim.delete();
        push_list('{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h99,
                    8'h01, 8'h04, 8'hFF, 8'hFF, 8'h11, 8'h22});
        run_download("wrap", 1'b0);
        check("wrap_w2_const", got_q.size() > 2 ? got_q[2] : 24'hFFFFFF, 24'h000022);

        // Download ends inside a data record
        stim.delete();
        push_list('{8'h01, 8'h06, 8'h00, 8'h60, 8'h11, 8'h22});
        run_download("trunc", 1'b0);
        check("trunc_err_const", load_err, 1);

        // Reset mid-record aborts writes and clears outputs
        stim.delete();
        got_q.delete();
        @(negedge clk);
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_clear_err", load_err, 0);
        foreach (stim[k]) send_byte(stim[k]);
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h00); send_byte(8'h60);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("rstmid_pre_nwr", got_q.size(), 3);
        @(negedge clk);
        in_wr = 1'b1;
        in_data = 8'h44;
        #2 reset = 1'b1;
        #1;
        check("rstmid_mem_wr", mem_wr, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_mem_data", mem_data, 0);
        check("rstmid_exec_addr", exec_addr, 0);
        check("rstmid_exec_valid", exec_valid, 0);
        check("rstmid_load_err", load_err, 0);
        @(negedge clk);
        in_wr = 1'b0;
        downloading = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_xa = 16'h0000;
        send_byte(8'h55);
        send_byte(8'h66);
        check("rstmid_post_nwr", got_q.size(), 3);
        stim.delete();
        push_list('{8'h01, 8'h04, 8'h10, 8'h60, 8'hA1, 8'hA2, 8'h02, 8'h02, 8'hCD, 8'hAB});
        run_download("after_rst", 1'b0);

        // Randomized files
        for (int f = 0; f < 12; f++) begin
            gen_random();
            run_download("rand", 1'b0);
        end

`ifdef CMD_LOADER_RAW_EN
        stim.delete();
        push_list('{8'h01, 8'h02, 8'h03});
        run_download("raw", 1'b1);
        check("raw_w0_const", got_q.size() > 0 ? got_q[0] : 24'h0, 24'h420001);
        check("raw_xv_const", exec_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
